// File: rtl/i2s_ws_frame_gen.sv
// Word-select / frame-sync generator for the I2S master: DSP short, DSP long, I2S and left-justified.
// Exports slot and bit position so the shifters follow the frame without their own counters.
module i2s_ws_frame_gen #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BITS_W  = 5,
    parameter int unsigned SLOTS_W = 3
) (
    input  logic               sck_i,
    input  logic               rstn_i,
    input  logic               cfg_en_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [BITS_W-1:0]  cfg_num_bits_i,
    input  logic [SLOTS_W-1:0] cfg_num_slots_i,
    input  logic [CNT_W-1:0]   cfg_setup_i,
    input  logic [BITS_W-1:0]  cfg_pulse_len_i,
    input  logic               cfg_ws_pol_i,
    output logic               ws_o,
    output logic               frame_start_o,
    output logic [SLOTS_W-1:0] slot_o,
    output logic [BITS_W-1:0]  bit_o,
    output logic               busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [1:0] MODE_DSP_SHORT = 2'd0;
    localparam logic [1:0] MODE_DSP_LONG  = 2'd1;
    localparam logic [1:0] MODE_I2S       = 2'd2;
    localparam logic [1:0] MODE_LJ        = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic [BITS_W-1:0]  bit_q, bit_d;
    logic [SLOTS_W-1:0] slot_q, slot_d;

    // Frame-shadowed configuration
    logic [1:0]         mode_q, mode_d;
    logic [BITS_W-1:0]  nbits_q, nbits_d;
    logic [SLOTS_W-1:0] nslots_q, nslots_d;
    logic [BITS_W-1:0]  plen_q, plen_d;
    logic               pol_q, pol_d;

    logic               ws_q, ws_d;
    logic               frame_start_q, frame_start_d;
    logic [SLOTS_W-1:0] slot_out_q, slot_out_d;
    logic [BITS_W-1:0]  bit_out_q, bit_out_d;
    logic               busy_q, busy_d;

    logic               bit_last_c;
    logic               slot_last_c;
    logic               latch_cfg_c;
    logic [SLOTS_W-1:0] next_slot_c;
    logic               ws_active_c;

    // Next-state, counters and shadow configuration
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        mode_d      = mode_q;
        nbits_d     = nbits_q;
        nslots_d    = nslots_q;
        plen_d      = plen_q;
        pol_d       = pol_q;
        latch_cfg_c = 1'b0;
        bit_last_c  = (bit_q == nbits_q);
        slot_last_c = (slot_q == nslots_q);

        case (state_q)
            ST_IDLE: begin
                bit_d  = '0;
                slot_d = '0;
                if (cfg_en_i) begin
                    setup_cnt_d = cfg_setup_i;
                    if (cfg_setup_i != '0) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d     = ST_RUN;
                        latch_cfg_c = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q <= CNT_W'(1)) begin
                    state_d     = ST_RUN;
                    setup_cnt_d = '0;
                    latch_cfg_c = 1'b1;
                end else begin
                    setup_cnt_d = setup_cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (bit_last_c) begin
                    bit_d = '0;
                    if (slot_last_c) begin
                        slot_d      = '0;
                        latch_cfg_c = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOTS_W'(1);
                    end
                end else begin
                    bit_d = bit_q + BITS_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!cfg_en_i) begin
            state_d     = ST_IDLE;
            setup_cnt_d = '0;
            bit_d       = '0;
            slot_d      = '0;
            latch_cfg_c = 1'b0;
        end

        if (latch_cfg_c) begin
            mode_d   = cfg_mode_i;
            nbits_d  = cfg_num_bits_i;
            nslots_d = cfg_num_slots_i;
            plen_d   = cfg_pulse_len_i;
            pol_d    = cfg_ws_pol_i;
        end
    end

    // Output stage: decodes the current counter position into WS and the exported position
    always_comb begin
        ws_d          = cfg_ws_pol_i;
        frame_start_d = 1'b0;
        slot_out_d    = '0;
        bit_out_d     = '0;
        busy_d        = 1'b0;
        ws_active_c   = 1'b0;
        next_slot_c   = slot_q;

        // I2S leads by one bit, so it looks at the slot of the following bit position
        if (bit_last_c) begin
            next_slot_c = slot_last_c ? '0 : slot_q + SLOTS_W'(1);
        end

        case (mode_q)
            MODE_DSP_SHORT: ws_active_c = (slot_q == '0) && (bit_q == '0);
            MODE_DSP_LONG:  ws_active_c = (slot_q == '0) && (bit_q <= plen_q);
            MODE_I2S:       ws_active_c = next_slot_c[0];
            MODE_LJ:        ws_active_c = ~slot_q[0];
            default:        ws_active_c = 1'b0;
        endcase

        if (cfg_en_i) begin
            case (state_q)
                ST_SETUP: begin
                    busy_d = 1'b1;
                end
                ST_RUN: begin
                    busy_d        = 1'b1;
                    ws_d          = ws_active_c ^ pol_q;
                    frame_start_d = (slot_q == '0) && (bit_q == '0);
                    slot_out_d    = slot_q;
                    bit_out_d     = bit_q;
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sck_i) begin
        if (!rstn_i) begin
            state_q       <= ST_IDLE;
            setup_cnt_q   <= '0;
            bit_q         <= '0;
            slot_q        <= '0;
            mode_q        <= '0;
            nbits_q       <= '0;
            nslots_q      <= '0;
            plen_q        <= '0;
            pol_q         <= 1'b0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            slot_out_q    <= '0;
            bit_out_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            setup_cnt_q   <= setup_cnt_d;
            bit_q         <= bit_d;
            slot_q        <= slot_d;
            mode_q        <= mode_d;
            nbits_q       <= nbits_d;
            nslots_q      <= nslots_d;
            plen_q        <= plen_d;
            pol_q         <= pol_d;
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            slot_out_q    <= slot_out_d;
            bit_out_q     <= bit_out_d;
            busy_q        <= busy_d;
        end
    end

    assign ws_o          = ws_q;
    assign frame_start_o = frame_start_q;
    assign slot_o        = slot_out_q;
    assign bit_o         = bit_out_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2s_ws_frame_gen.sv
// Directed bench for i2s_ws_frame_gen: a vector table for reset/setup timing plus
// hand-written frame sequences with closed-form expected WS patterns.
module tb_i2s_ws_frame_gen;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BITS_W  = 5;
    localparam int unsigned SLOTS_W = 3;

    logic               sck_i;
    logic               rstn_i;
    logic               cfg_en_i;
    logic [1:0]         cfg_mode_i;
    logic [BITS_W-1:0]  cfg_num_bits_i;
    logic [SLOTS_W-1:0] cfg_num_slots_i;
    logic [CNT_W-1:0]   cfg_setup_i;
    logic [BITS_W-1:0]  cfg_pulse_len_i;
    logic               cfg_ws_pol_i;
    logic               ws_o;
    logic               frame_start_o;
    logic [SLOTS_W-1:0] slot_o;
    logic [BITS_W-1:0]  bit_o;
    logic               busy_o;

    int n_cmp;
    int n_err;

    i2s_ws_frame_gen #(
        .CNT_W  (CNT_W),
        .BITS_W (BITS_W),
        .SLOTS_W(SLOTS_W)
    ) dut (
        .sck_i          (sck_i),
        .rstn_i         (rstn_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_num_bits_i (cfg_num_bits_i),
        .cfg_num_slots_i(cfg_num_slots_i),
        .cfg_setup_i    (cfg_setup_i),
        .cfg_pulse_len_i(cfg_pulse_len_i),
        .cfg_ws_pol_i   (cfg_ws_pol_i),
        .ws_o           (ws_o),
        .frame_start_o  (frame_start_o),
        .slot_o         (slot_o),
        .bit_o          (bit_o),
        .busy_o         (busy_o)
    );

    initial begin
        sck_i = 1'b0;
        forever #5 sck_i = ~sck_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rstn;
        logic        en;
        logic [15:0] setup;
        logic        pol;
        int          ws;
        int          fs;
        int          slot;
        int          bt;
        int          busy;
    } vec_t;

    task automatic tick();
        @(posedge sck_i);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int ws, input int fs,
                              input int sl, input int bt, input int bz);
        check({tag, ".ws"},    int'(ws_o),          ws);
        check({tag, ".fs"},    int'(frame_start_o), fs);
        check({tag, ".slot"},  int'(slot_o),        sl);
        check({tag, ".bit"},   int'(bit_o),         bt);
        check({tag, ".busy"},  int'(busy_o),        bz);
    endtask

    // Disable for one edge, load config, enable; the enabling edge is edge 0 (outputs still idle)
    task automatic start(input logic [1:0] m, input int nb, input int ns, input int pl,
                         input logic pol, input int su);
        cfg_en_i = 1'b0;
        tick();
        cfg_mode_i      = m;
        cfg_num_bits_i  = BITS_W'(nb);
        cfg_num_slots_i = SLOTS_W'(ns);
        cfg_pulse_len_i = BITS_W'(pl);
        cfg_ws_pol_i    = pol;
        cfg_setup_i     = CNT_W'(su);
        cfg_en_i        = 1'b1;
        tick();
        expect_out("start_idle", int'(pol), 0, 0, 0, 0);
    endtask

    task automatic wait_s1b5(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (slot_o == SLOTS_W'(1) && bit_o == BITS_W'(5)) begin
                found = 1;
                break;
            end
        end
        check({tag, ".reach_s1b5"}, found, 1);
    endtask

    vec_t vecs[11];

    initial begin
        int pos;
        n_cmp = 0;
        n_err = 0;
        rstn_i          = 1'b0;
        cfg_en_i        = 1'b0;
        cfg_mode_i      = 2'd0;
        cfg_num_bits_i  = BITS_W'(15);
        cfg_num_slots_i = SLOTS_W'(1);
        cfg_setup_i     = '0;
        cfg_pulse_len_i = '0;
        cfg_ws_pol_i    = 1'b1;

        // rstn, en, setup, pol | ws, fs, slot, bit, busy
        vecs[0]  = '{1'b0, 1'b0, 16'd0, 1'b1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 16'd0, 1'b0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b1, 16'd3, 1'b0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1'b1, 1'b1, 16'd3, 1'b0, 0, 0, 0, 0, 1};
        vecs[5]  = '{1'b1, 1'b1, 16'd3, 1'b0, 0, 0, 0, 0, 1};
        vecs[6]  = '{1'b1, 1'b1, 16'd3, 1'b0, 0, 0, 0, 0, 1};
        vecs[7]  = '{1'b1, 1'b1, 16'd3, 1'b0, 1, 1, 0, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 16'd3, 1'b0, 0, 0, 0, 1, 1};
        vecs[9]  = '{1'b1, 1'b1, 16'd3, 1'b0, 0, 0, 0, 2, 1};
        vecs[10] = '{1'b1, 1'b0, 16'd3, 1'b0, 0, 0, 0, 0, 0};

        @(negedge sck_i);
        for (int i = 0; i < 11; i++) begin
            rstn_i       = vecs[i].rstn;
            cfg_en_i     = vecs[i].en;
            cfg_setup_i  = vecs[i].setup;
            cfg_ws_pol_i = vecs[i].pol;
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].ws, vecs[i].fs,
                       vecs[i].slot, vecs[i].bt, vecs[i].busy);
        end

        // DSP short, 16-bit slots, 2 slots: pulse at edges 1, 33, 65
        start(2'd0, 15, 1, 0, 1'b0, 0);
        for (int k = 1; k <= 70; k++) begin
            tick();
            pos = (k - 1) % 32;
            expect_out("dsp_short", int'(pos == 0), int'(pos == 0), pos / 16, pos % 16, 1);
        end

        // DSP long, pulse_len=3 -> 4 cycles high per frame
        start(2'd1, 15, 1, 3, 1'b0, 0);
        for (int k = 1; k <= 64; k++) begin
            tick();
            pos = (k - 1) % 32;
            expect_out("dsp_long3", int'(pos < 4), int'(pos == 0), pos / 16, pos % 16, 1);
        end

        // DSP long, pulse_len beyond the slot -> whole of slot 0
        start(2'd1, 15, 1, 20, 1'b0, 0);
        for (int k = 1; k <= 64; k++) begin
            tick();
            pos = (k - 1) % 32;
            expect_out("dsp_long20", int'(pos < 16), int'(pos == 0), pos / 16, pos % 16, 1);
        end

        // I2S, 8-bit slots: WS leads the slot boundary by one bit
        start(2'd2, 7, 1, 0, 1'b0, 0);
        for (int k = 1; k <= 48; k++) begin
            tick();
            pos = (k - 1) % 16;
            expect_out("i2s", int'(pos >= 7 && pos < 15), int'(pos == 0), pos / 8, pos % 8, 1);
        end

        // I2S with a single slot keeps WS low
        start(2'd2, 3, 0, 0, 1'b0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            pos = (k - 1) % 4;
            expect_out("i2s_1slot", 0, int'(pos == 0), 0, pos, 1);
        end

        // Left-justified, 4 slots of 4 bits: WS high on even slots
        start(2'd3, 3, 3, 0, 1'b0, 0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            pos = (k - 1) % 16;
            expect_out("lj", int'(((pos / 4) % 2) == 0), int'(pos == 0), pos / 4, pos % 4, 1);
        end

        // Mid-frame change of num_bits and polarity applies from the next frame
        start(2'd0, 7, 1, 0, 1'b0, 0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin
                cfg_num_bits_i = BITS_W'(3);
                cfg_ws_pol_i   = 1'b1;
            end
            tick();
            pos = (k - 1) % 16;
            expect_out("shadow_old", int'(pos == 0), int'(pos == 0), pos / 8, pos % 8, 1);
        end
        for (int k = 17; k <= 40; k++) begin
            tick();
            pos = (k - 17) % 8;
            expect_out("shadow_new", int'(pos != 0), int'(pos == 0), pos / 4, pos % 4, 1);
        end

        // Drop enable at slot 1 bit 5, re-enable two cycles later
        start(2'd0, 15, 1, 0, 1'b0, 0);
        wait_s1b5("drop");
        cfg_en_i = 1'b0;
        tick();
        expect_out("drop_idle0", 0, 0, 0, 0, 0);
        tick();
        expect_out("drop_idle1", 0, 0, 0, 0, 0);
        cfg_en_i = 1'b1;
        tick();
        expect_out("reen_edge0", 0, 0, 0, 0, 0);
        tick();
        expect_out("reen_first", 1, 1, 0, 0, 1);

        // Same drop point but via synchronous reset with inverted polarity
        start(2'd0, 15, 1, 0, 1'b1, 0);
        wait_s1b5("rst");
        check("rst.ws_before", int'(ws_o), 1);
        rstn_i = 1'b0;
        tick();
        expect_out("rst_zero", 0, 0, 0, 0, 0);
        rstn_i = 1'b1;
        tick();
        expect_out("rst_idle", 1, 0, 0, 0, 0);
        tick();
        expect_out("rst_first", 0, 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
